qspi_flash_responder: RTL and testbench

Synthesizable responder (target) end of the QSPI flash link driven by the team's QSPI memory controller. It decodes the controller's command stream and serves the commands that stream uses: RDID, WREN, WRSR and fast quad I/O read (0xEB), from an internal word-organised array. It is used as the flash model in simulation and FPGA bring-up, on the same clock as the controller. A backdoor load port preloads the array.

---
 rtl/qspi_flash_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_responder.sv
// QSPI flash responder: serves RDID (0xAB), WREN, WRSR and quad I/O fast read (0xEB)
// from a word-organised array that can be preloaded through a backdoor port.
module qspi_flash_responder #(
    parameter int         DEPTH  = 32,
    parameter logic [7:0] DEV_ID = 8'h15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs_n,
    input  logic [3:0]               dq_i,
    output logic [3:0]               dq_o,
    output logic [3:0]               dq_oe,
    output logic [15:0]              status,
    output logic                     wel,
    output logic                     busy,
    output logic                     cmd_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int AW = $clog2(DEPTH);
    // Shift path is just wide enough for a 16-bit WRSR word or the address bits that index the array.
    localparam int NW = (AW + 10 > 16) ? AW + 10 : 16;
    localparam int SW = NW - 4;

    typedef enum logic [3:0] {
        IDLE, CMD, RDID_DMY, RDID_OUT, WRSR_DAT, ADDR, DMY, READ, HOLD
    } state_t;

    state_t          state, state_d;
    logic [4:0]      cnt, cnt_d;
    logic [SW-1:0]   shreg, shreg_d;
    logic [AW-1:0]   word_idx, word_idx_d;
    logic [3:0]      dq_o_d, dq_oe_d;
    logic [15:0]     status_d;
    logic            wel_d, cmd_err_d;

    logic [31:0]     mem [DEPTH];
    logic [SW-1:0]   ser_in;
    logic [NW-1:0]   quad_in;
    logic [7:0]      opcode;
    logic [AW-1:0]   next_idx;
    logic [31:0]     cur_word, next_word, word_sh;
    logic [7:0]      id_sh;

    assign ser_in    = {shreg[SW-2:0], dq_i[0]};
    assign quad_in   = {shreg, dq_i};
    assign opcode    = ser_in[7:0];
    assign next_idx  = word_idx + 1'b1;
    assign cur_word  = mem[word_idx];
    assign next_word = mem[next_idx];
    assign word_sh   = cur_word << {cnt[2:0], 2'b00};
    assign id_sh     = DEV_ID << cnt[2:0];
    assign busy      = (state != IDLE);

    // NOTE: the array has no reset so it maps onto plain RAM and survives a mid-transaction reset.
    always_ff @(posedge clk) begin
        if (load_en && state == IDLE)
            mem[load_addr] <= load_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            word_idx <= '0;
            dq_o     <= '0;
            dq_oe    <= '0;
            status   <= '0;
            wel      <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            shreg    <= shreg_d;
            word_idx <= word_idx_d;
            dq_o     <= dq_o_d;
            dq_oe    <= dq_oe_d;
            status   <= status_d;
            wel      <= wel_d;
            cmd_err  <= cmd_err_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = 5'd1;
                end
                CMD: begin
                    if (cnt == 5'd7) begin
                        cnt_d = '0;
                        case (opcode)
                            8'hAB:   state_d = RDID_DMY;
                            8'h01:   state_d = WRSR_DAT;
                            8'hEB:   state_d = ADDR;
                            default: state_d = HOLD;
                        endcase
                    end else begin
                        cnt_d = cnt + 5'd1;
                    end
                end
                RDID_DMY: begin
                    if (cnt == 5'd23) begin
                        state_d = RDID_OUT;
                        cnt_d   = 5'd1;
                    end else begin
                        cnt_d = cnt + 5'd1;
                    end
                end
                RDID_OUT: begin
                    if (cnt == 5'd8) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 5'd1;
                    end
                end
                WRSR_DAT: begin
                    if (cnt == 5'd3) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 5'd1;
                    end
                end
                ADDR: begin
                    if (cnt == 5'd7) begin
                        state_d = DMY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 5'd1;
                    end
                end
                DMY: begin
                    if (cnt == 5'd3) begin
                        state_d = READ;
                        cnt_d   = 5'd1;
                    end else begin
                        cnt_d = cnt + 5'd1;
                    end
                end
                READ: begin
                    // cnt counts nibbles already driven from the current word.
                    cnt_d = (cnt == 5'd8) ? 5'd1 : cnt + 5'd1;
                end
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dq_o_d     = dq_o;
        dq_oe_d    = dq_oe;
        status_d   = status;
        wel_d      = wel;
        cmd_err_d  = 1'b0;
        shreg_d    = shreg;
        word_idx_d = word_idx;
        if (cs_n) begin
            dq_o_d  = '0;
            dq_oe_d = '0;
        end else begin
            case (state)
                IDLE: shreg_d = ser_in;
                CMD: begin
                    shreg_d = ser_in;
                    if (cnt == 5'd7) begin
                        case (opcode)
                            8'h06:                   wel_d     = 1'b1;
                            8'hAB, 8'h01, 8'hEB:     cmd_err_d = 1'b0;
                            default:                 cmd_err_d = 1'b1;
                        endcase
                    end
                end
                RDID_DMY: begin
                    if (cnt == 5'd23) begin
                        dq_o_d  = {2'b00, DEV_ID[7], 1'b0};
                        dq_oe_d = 4'b0010;
                    end
                end
                RDID_OUT: begin
                    if (cnt == 5'd8) begin
                        dq_o_d  = '0;
                        dq_oe_d = '0;
                    end else begin
                        dq_o_d = {2'b00, id_sh[7], 1'b0};
                    end
                end
                WRSR_DAT: begin
                    shreg_d = quad_in[SW-1:0];
                    if (cnt == 5'd3) begin
                        if (wel)
                            status_d = quad_in[15:0];
                        wel_d = 1'b0;
                    end
                end
                ADDR: begin
                    shreg_d = quad_in[SW-1:0];
                    // Address sits above the 8 mode bits; its low 2 bits select a byte and are dropped.
                    if (cnt == 5'd7)
                        word_idx_d = quad_in[AW+9:10];
                end
                DMY: begin
                    if (cnt == 5'd3) begin
                        dq_o_d  = cur_word[31:28];
                        dq_oe_d = 4'hF;
                    end
                end
                READ: begin
                    if (cnt == 5'd8) begin
                        word_idx_d = next_idx;
                        dq_o_d     = next_word[31:28];
                    end else begin
                        dq_o_d = word_sh[31:28];
                    end
                end
                HOLD: begin
                    dq_o_d  = '0;
                    dq_oe_d = '0;
                end
                default: begin
                    dq_o_d  = '0;
                    dq_oe_d = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder; expected output units are queued when a
// command is issued and popped as the responder drives them.
module tb_qspi_flash_responder;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_n;
    logic [3:0]    dq_i;
    logic [3:0]    dq_o;
    logic [3:0]    dq_oe;
    logic [15:0]   status;
    logic          wel;
    logic          busy;
    logic          cmd_err;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;

    typedef struct {
        logic [3:0] dq;
        logic [3:0] oe;
        logic [3:0] mask;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [7:0]  dev_id   = 8'h15;

    qspi_flash_responder #(.DEPTH(DEPTH), .DEV_ID(8'h15)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .dq_i      (dq_i),
        .dq_o      (dq_o),
        .dq_oe     (dq_oe),
        .status    (status),
        .wel       (wel),
        .busy      (busy),
        .cmd_err   (cmd_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_serial(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cs_n = 1'b0;
            dq_i = {3'b000, v[i]};
            step();
        end
    endtask

    task automatic send_quad(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cs_n = 1'b0;
            dq_i = v[4*i +: 4];
            step();
        end
    endtask

    task automatic end_txn();
        cs_n = 1'b1;
        dq_i = 4'h0;
        step();
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 7; i >= 0; i--)
            sb.push_back('{dq: w[4*i +: 4], oe: 4'hF, mask: 4'hF});
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb_empty observed=0 expected=nonzero", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_dq"}, 32'(dq_o & e.mask), 32'(e.dq & e.mask));
            chk({tag, "_oe"}, 32'(dq_oe), 32'(e.oe));
        end
    endtask

    task automatic out_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            dq_i = 4'h0;
            step();
            check_out(tag);
        end
    endtask

    // Issues 0xEB up to the 4th dummy nibble and checks the first output nibble.
    task automatic read_start(input logic [23:0] addr, input string tag);
        send_serial(32'hEB, 8);
        send_quad({addr, 8'hA5}, 8);
        send_quad(32'h0, 4);
        check_out(tag);
    endtask

    initial begin
        rst     = 1'b1;
        cs_n    = 1'b1;
        dq_i    = 4'h0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_dq_oe",   32'(dq_oe),   32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_wel",     32'(wel),     32'h0);
        chk("rst_status",  32'(status),  32'h0);
        chk("rst_cmd_err", 32'(cmd_err), 32'h0);
        step();
        step();
        rst = 1'b1;
        step();

        load(5'd5,  32'hDEADBEEF);
        load(5'd31, 32'h01234567);
        load(5'd0,  32'h89ABCDEF);

        // RDID: DEV_ID on DQ1 only for 8 cycles, then drive released
        send_serial(32'hAB, 8);
        send_serial(32'h0, 24);
        for (int i = 7; i >= 0; i--)
            sb.push_back('{dq: {2'b00, dev_id[i], 1'b0}, oe: 4'b0010, mask: 4'b0010});
        check_out("rdid");
        out_cycles(7, "rdid");
        step();
        chk("rdid_oe_drop", 32'(dq_oe), 32'h0);
        chk("rdid_busy_hold", 32'(busy), 32'h1);
        end_txn();
        chk("rdid_busy_end", 32'(busy), 32'h0);

        // WRSR without WREN: status untouched
        send_serial(32'h01, 8);
        send_quad(32'h0200, 4);
        chk("wrsr_nowel_status", 32'(status), 32'h0);
        chk("wrsr_nowel_wel", 32'(wel), 32'h0);
        end_txn();

        // WREN then WRSR 0x0200
        send_serial(32'h06, 8);
        chk("wren_wel", 32'(wel), 32'h1);
        end_txn();
        chk("wren_wel_kept", 32'(wel), 32'h1);
        send_serial(32'h01, 8);
        send_quad(32'h0200, 4);
        chk("wrsr_status", 32'(status), 32'h0200);
        chk("wrsr_wel_clr", 32'(wel), 32'h0);
        end_txn();

        // Partial WRSR aborted after 2 nibbles
        send_serial(32'h06, 8);
        end_txn();
        send_serial(32'h01, 8);
        send_quad(32'hAB, 2);
        end_txn();
        chk("wrsr_part_status", 32'(status), 32'h0200);
        chk("wrsr_part_busy", 32'(busy), 32'h0);
        chk("wrsr_part_wel", 32'(wel), 32'h1);

        // Unknown opcode: single cmd_err pulse, no drive
        send_serial(32'h9F, 8);
        chk("bad_cmd_err_hi", 32'(cmd_err), 32'h1);
        chk("bad_cmd_oe", 32'(dq_oe), 32'h0);
        dq_i = 4'h0;
        step();
        chk("bad_cmd_err_lo", 32'(cmd_err), 32'h0);
        chk("bad_cmd_busy", 32'(busy), 32'h1);
        chk("bad_cmd_oe2", 32'(dq_oe), 32'h0);
        end_txn();

        // Quad read of word 5 (byte address 0x14)
        push_word(model_mem[5]);
        read_start(24'h000014, "rd5");
        out_cycles(7, "rd5");
        end_txn();
        chk("rd5_oe_off", 32'(dq_oe), 32'h0);

        // Read from word DEPTH-1 wraps to word 0; a load attempted mid-read must be ignored
        push_word(model_mem[DEPTH-1]);
        push_word(model_mem[0]);
        read_start(24'(32'(DEPTH - 1) * 4), "rdwrap");
        out_cycles(2, "rdwrap");
        load_en   = 1'b1;
        load_addr = 5'd0;
        load_data = 32'hFFFFFFFF;
        out_cycles(1, "rdwrap");
        load_en   = 1'b0;
        out_cycles(12, "rdwrap");
        end_txn();
        chk("rdwrap_sb_drained", 32'(sb.size()), 32'h0);

        // Async reset mid-READ
        push_word(model_mem[5]);
        read_start(24'h000014, "rdrst");
        out_cycles(2, "rdrst");
        rst = 1'b0;
        #1;
        chk("mrst_dq_oe",  32'(dq_oe),  32'h0);
        chk("mrst_busy",   32'(busy),   32'h0);
        chk("mrst_wel",    32'(wel),    32'h0);
        chk("mrst_status", 32'(status), 32'h0);
        sb.delete();
        cs_n = 1'b1;
        step();
        rst = 1'b1;
        step();

        // Array survives reset
        push_word(model_mem[5]);
        read_start(24'h000016, "rdpost");
        out_cycles(7, "rdpost");
        end_txn();
        push_word(model_mem[0]);
        read_start(24'h000000, "rd0");
        out_cycles(7, "rd0");
        end_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
